gap_junction_stimulus: RTL

AXI4-Stream transmitter that drives the input stream of the GapJunction HLS core. It holds off for a programmable start-up delay, then sends a fixed number of frames. Each frame is a fixed number of 32-bit words and ends with TLAST. A programmable idle gap separates frames. It is the source-side counterpart of the output checker and is used for on-board bring-up and regression of the core.

---
 rtl/gap_junction_stimulus.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/gap_junction_stimulus.sv
// gap_junction_stimulus: AXI4-Stream source for the GapJunction HLS core.
// After a start-up delay it sends Num_Frames frames of Words_Per_Frame
// 32-bit words. TLAST marks the last word of each frame, and Gap_Cycles idle
// cycles separate the frames. Done stays high once every frame is sent.
// Optional build macro PRBS_DATA_EN: when defined, TDATA comes from a 32-bit
// Galois LFSR instead of the {frame,word} counter pattern.
module gap_junction_stimulus #(
  parameter logic [19:0] Start_Delay_Value = 20'd20000,
  parameter logic [15:0] Words_Per_Frame   = 16'd8,
  parameter logic [15:0] Num_Frames        = 16'd4,
  parameter logic [7:0]  Gap_Cycles        = 8'd2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        input_r_TVALID_0,
  input  logic        input_r_TREADY_0,
  output logic [31:0] input_r_TDATA_0,
  output logic        input_r_TLAST_0,
  output logic [15:0] Frame_Counter,
  output logic        Done
);

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [19:0] r_delay_cnt;
  logic [19:0] w_delay_next;
  logic [7:0]  r_gap_cnt;
  logic [7:0]  w_gap_next;
  logic [15:0] r_word_idx;
  logic [15:0] w_word_next;
  logic [15:0] r_frame_cnt;
  logic [15:0] w_frame_next;
  logic        r_tvalid;
  logic        r_tlast;
  logic        r_done;
  logic [31:0] r_tdata;
  logic        w_beat;
  logic        w_last_word;

  assign w_beat      = r_tvalid & input_r_TREADY_0;
  assign w_last_word = (r_word_idx == (Words_Per_Frame - 16'd1));

`ifdef PRBS_DATA_EN
  logic [31:0] r_lfsr;
  logic [31:0] w_lfsr_next;

  // One right-shift step of the Galois LFSR for x^32+x^22+x^2+x+1.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic [31:0] n;
    n = {1'b0, s[31:1]};
    if (s[0]) begin
      n = n ^ 32'h8020_0003;
    end else begin
      n = n;
    end
    return n;
  endfunction

  // Advance the LFSR only on a beat, so the word holds still under backpressure.
  always_comb begin
    w_lfsr_next = r_lfsr;
    if (w_beat) begin
      w_lfsr_next = lfsr_step(r_lfsr);
    end else begin
      w_lfsr_next = r_lfsr;
    end
  end

  // LFSR state register, seeded at reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lfsr <= 32'hACE1_0001;
    end else begin
      r_lfsr <= w_lfsr_next;
    end
  end
`endif

  // Next-state and counter update logic.
  always_comb begin
    w_state_next = r_state;
    w_delay_next = r_delay_cnt;
    w_gap_next   = r_gap_cnt;
    w_word_next  = r_word_idx;
    w_frame_next = r_frame_cnt;
    case (r_state)
      ST_WAIT: begin
        w_delay_next = r_delay_cnt + 20'd1;
        if ((Start_Delay_Value == 20'd0) ||
            (r_delay_cnt == (Start_Delay_Value - 20'd1))) begin
          w_state_next = ST_SEND;
        end else begin
          w_state_next = ST_WAIT;
        end
      end
      ST_SEND: begin
        if (w_beat) begin
          if (w_last_word) begin
            w_word_next  = 16'd0;
            w_frame_next = r_frame_cnt + 16'd1;
            if ((r_frame_cnt + 16'd1) == Num_Frames) begin
              w_state_next = ST_DONE;
            end else if (Gap_Cycles != 8'd0) begin
              w_state_next = ST_GAP;
              w_gap_next   = 8'd0;
            end else begin
              w_state_next = ST_SEND;
            end
          end else begin
            w_word_next = r_word_idx + 16'd1;
          end
        end else begin
          w_state_next = ST_SEND;
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == (Gap_Cycles - 8'd1)) begin
          w_state_next = ST_SEND;
        end else begin
          w_gap_next = r_gap_cnt + 8'd1;
        end
      end
      ST_DONE: begin
        w_state_next = ST_DONE;
      end
      default: begin
        w_state_next = ST_WAIT;
      end
    endcase
  end

  // State, counters and registered stream outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_WAIT;
      r_delay_cnt <= 20'd0;
      r_gap_cnt   <= 8'd0;
      r_word_idx  <= 16'd0;
      r_frame_cnt <= 16'd0;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_done      <= 1'b0;
      r_tdata     <= 32'd0;
    end else begin
      r_state     <= w_state_next;
      r_delay_cnt <= w_delay_next;
      r_gap_cnt   <= w_gap_next;
      r_word_idx  <= w_word_next;
      r_frame_cnt <= w_frame_next;
      r_tvalid    <= (w_state_next == ST_SEND);
      r_tlast     <= (w_state_next == ST_SEND) &&
                     (w_word_next == (Words_Per_Frame - 16'd1));
      r_done      <= (w_state_next == ST_DONE);
`ifdef PRBS_DATA_EN
      r_tdata     <= w_lfsr_next;
`else
      r_tdata     <= {w_frame_next, w_word_next};
`endif
    end
  end

  assign input_r_TVALID_0 = r_tvalid;
  assign input_r_TLAST_0  = r_tlast;
  assign input_r_TDATA_0  = r_tdata;
  assign Frame_Counter    = r_frame_cnt;
  assign Done             = r_done;

endmodule
